// File: rtl/multu_arb_seq.sv
// Two-requester round-robin front end for a WIDTH-cycle shift-and-add unsigned multiplier.
// Accept to rsp_valid is WIDTH cycles. rsp_ready low holds DONE with outputs frozen, and no new request is accepted.
module multu_arb_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_z,
  input  logic               rsp_ready,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic               last_winner;
  logic               id;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;

  logic               gnt0;
  logic               gnt1;
  logic               accept;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // A tie goes to whichever requester did not win the previous grant.
  always_comb begin
    gnt0   = req0_valid & (~req1_valid | last_winner);
    gnt1   = req1_valid & (~req0_valid | ~last_winner);
    sel_a  = gnt1 ? req1_a : req0_a;
    sel_b  = gnt1 ? req1_b : req0_b;
    accept = req0_ready | req1_ready;
  end

  assign req0_ready = (state == IDLE) & gnt0 & reset;
  assign req1_ready = (state == IDLE) & gnt1 & reset;
  assign rsp_z      = acc;
  assign rsp_id     = id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      id          <= 1'b0;
      mcand       <= '0;
      acc         <= '0;
      mplr        <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand       <= {{WIDTH{1'b0}}, sel_a};
            mplr        <= sel_b;
            acc         <= '0;
            cnt         <= CW'(WIDTH);
            id          <= gnt1;
            last_winner <= gnt1;
            busy        <= 1'b1;
            state       <= CALC;
          end
        end
        CALC: begin
          // Fixed WIDTH iterations regardless of operand values.
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/multu_arb_seq.md
# multu_arb_seq

Sequencing and arbitration controller for the 4-bit unsigned multiplier path. It accepts multiply requests from two requesters and grants the shared resource round-robin. It runs each accepted operation as a WIDTH-cycle shift-and-add sequence and returns the 2·WIDTH-bit product with the winning requester's ID over a valid/ready response channel. It sits between the operand sources and the result consumer, in place of a free-running combinational multiplier.

## Interface
- WIDTH, 4, operand width in bits; product width is 2·WIDTH.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; low clears all state immediately.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_a  input  WIDTH  requester 0 multiplicand.
- req0_b  input  WIDTH  requester 0 multiplier.
- req0_ready  output  1  requester 0 operands accepted this cycle when high with req0_valid.
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- rsp_valid  output  1  product available.
- rsp_id  output  1  requester index that owns the product.
- rsp_z  output  2·WIDTH  unsigned product a·b.
- rsp_ready  input  1  consumer accepts the product.
- busy  output  1  high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE, arbitration:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester that did not win last.
  - last_winner resets to 1, so requester 0 wins the first tie.
- IDLE, ready:
  - reqN_ready = (state==IDLE) & granted N & reset high. It is combinational, and at most one ready is high.
- IDLE, accept (valid & ready at an edge):
  - mcand ← zero-extended a (2·WIDTH bits); mplr ← b; acc ← 0; cnt ← WIDTH.
  - id ← granted index; last_winner ← granted index; go to CALC.
- CALC, each edge:
  - If mplr[0], acc ← acc + mcand, computed with 2·WIDTH-bit arithmetic (cannot overflow).
  - mcand ← mcand << 1; mplr ← mplr >> 1; cnt ← cnt − 1.
  - When cnt reaches 0 after this edge, go to DONE.
  - No early termination: zero or small operands still take exactly WIDTH cycles.
- DONE:
  - rsp_valid=1, rsp_z=acc, rsp_id=id.
  - Hold all three stable until rsp_valid & rsp_ready at an edge, then go to IDLE.
- Requests arriving during CALC/DONE see ready=0. Requesters hold valid and operands until accepted; the block never drops a held request.
- Reset low at any time, including mid-CALC or while rsp_valid is high:
  - State returns to IDLE, and the in-flight operation is discarded with no response.
  - last_winner returns to 1.
- Reset values: req0_ready=0, req1_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, busy=0.

## Timing
- Accept at edge k. CALC occupies edges k+1 … k+WIDTH. rsp_valid is high after edge k+WIDTH.
  - WIDTH=4: accept at edge k, response visible after edge k+4.
- With rsp_ready held high, the response handshake completes at edge k+WIDTH+1. IDLE lasts at least one cycle, so the next accept is at edge k+WIDTH+2 at the earliest.
- Minimum issue interval is WIDTH+2 cycles (6 for WIDTH=4).
- rsp_ready low stalls in DONE indefinitely, with outputs frozen.
- Ready is a combinational function of state, grant and valid inputs only. There is no combinational path from rsp_ready to reqN_ready.

## Test plan
- Reset then single requests on req0:
  - (3,1) → rsp_z=3, rsp_id=0, rsp_valid exactly 4 edges after accept.
  - Then (4,4) → 16.
- Boundary operands:
  - (0,0) → 0, still 4 CALC cycles.
  - (15,1) → 15.
  - (15,15) → 225.
  - (2,8) → 16.
- Contention: both valid continuously, req0=(2,3), req1=(5,5).
  - Grants alternate 0,1,0,1 starting with 0.
  - Products 6 and 25 with matching rsp_id.
  - Never both ready high.
- Backpressure: rsp_ready low for 10 cycles in DONE.
  - rsp_z/rsp_id stable, both readies stay 0, no new accept.
  - Release → handshake, then the next accept no earlier than 1 cycle later.
- Reset mid-operation: assert reset low on the 2nd CALC cycle of (7,7).
  - All outputs 0 immediately, and no response for 7·7 ever appears.
  - After release, a tie grants req0 first.
- Streaming: 20 random operand pairs from both requesters with random rsp_ready.
  - Every product matches a·b, responses come in grant order, none lost or duplicated.
